top_level_instantiation: RTL and testbench

- Self-contained Hamming SECDED encoder engine with its own byte-wide data memory.
- On a start request, it reads 15 eleven-bit messages from memory bytes 0..29.
- For each message it computes the 4 Hamming parity bits plus 1 overall parity bit and writes the 16-bit codewords to bytes 30..59.
- Signals completion on ack; it is the top level of the program-1 design.

---
 rtl/hamming_pkg.sv | 37 +++
 rtl/data_mem.sv | 23 ++
 rtl/top_level_instantiation.sv | 106 ++++++++++
 tb/tb_top_level_instantiation.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared constants, FSM state type and the SECDED codeword function for the
// program-1 Hamming encoder engine.
package hamming_pkg;

   localparam int NUM_MSG   = 15;
   localparam int SRC_BASE  = 0;
   localparam int DST_BASE  = 30;
   localparam int MEM_DEPTH = 256;
   localparam int AW        = $clog2(MEM_DEPTH);
   localparam int IDX_W     = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD_LO = 3'd1,
      S_RD_HI = 3'd2,
      S_WR_HI = 3'd3,
      S_WR_LO = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   // Returns {high byte, low byte} as laid out in memory:
   // high = {d11..d5, p8}, low = {d4, d3, d2, p4, d1, p2, p1, p0}.
   function automatic logic [15:0] hamming_encode(input logic [11:1] d);
      logic p8;
      logic p4;
      logic p2;
      logic p1;
      logic p0;
      p8 = ^d[11:5];
      p4 = d[11] ^ d[10] ^ d[9] ^ d[8] ^ d[4] ^ d[3] ^ d[2];
      p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
      p1 = d[11] ^ d[9]  ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
      p0 = ^{d, p8, p4, p2, p1};
      return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
   endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: combinational read, synchronous write, no reset so
// contents survive a reset of the engine.
module data_mem
   import hamming_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [7:0]    i_wdata,
   output logic [7:0]    o_rdata
);

   logic [7:0] core [0:MEM_DEPTH-1];

   assign o_rdata = core[i_addr];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         core[i_addr] <= i_wdata;
      end
   end

endmodule

// File: rtl/top_level_instantiation.sv
// Hamming SECDED encoder engine: reads 15 eleven-bit messages from its own
// memory, writes the 16-bit codewords back, and raises ack when finished.
module top_level_instantiation
   import hamming_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic req,
   output logic ack
);

   state_t           r_state;
   state_t           w_next;
   logic [IDX_W-1:0] r_idx;
   logic [11:1]      r_d;

   logic             w_we;
   logic [AW-1:0]    w_addr;
   logic [7:0]       w_wdata;
   logic [7:0]       w_rdata;
   logic [AW-1:0]    w_off;
   logic [15:0]      w_code;
   logic             w_last;

   // Byte offset of message/codeword i is 2*i from its base.
   assign w_off  = {{(AW-IDX_W-1){1'b0}}, r_idx, 1'b0};
   assign w_code = hamming_encode(r_d);
   assign w_last = (r_idx == IDX_W'(NUM_MSG - 1));

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_d     <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (req) begin
                  r_idx <= '0;
               end
            end
            S_RD_LO: r_d[8:1]  <= w_rdata;
            S_RD_HI: r_d[11:9] <= w_rdata[2:0];
            S_WR_LO: begin
               if (!w_last) begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Next state plus memory port control; req only matters in IDLE/DONE.
   always_comb begin
      w_next  = r_state;
      w_we    = 1'b0;
      w_addr  = AW'(SRC_BASE) + w_off;
      w_wdata = 8'h00;
      ack     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req) begin
               w_next = S_RD_LO;
            end
         end
         S_RD_LO: begin
            w_addr = AW'(SRC_BASE) + w_off;
            w_next = S_RD_HI;
         end
         S_RD_HI: begin
            w_addr = AW'(SRC_BASE) + w_off + AW'(1);
            w_next = S_WR_HI;
         end
         S_WR_HI: begin
            w_we    = 1'b1;
            w_addr  = AW'(DST_BASE) + w_off + AW'(1);
            w_wdata = w_code[15:8];
            w_next  = S_WR_LO;
         end
         S_WR_LO: begin
            w_we    = 1'b1;
            w_addr  = AW'(DST_BASE) + w_off;
            w_wdata = w_code[7:0];
            w_next  = w_last ? S_DONE : S_RD_LO;
         end
         S_DONE: begin
            ack = 1'b1;
            if (req) begin
               w_next = S_RD_LO;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   data_mem DM (
      .i_clk   (clock),
      .i_we    (w_we),
      .i_addr  (w_addr),
      .i_wdata (w_wdata),
      .o_rdata (w_rdata)
   );

endmodule

// File: tb/tb_top_level_instantiation.sv
// Bench for the Hamming encoder engine: memory writes are checked against an
// expected queue by a monitor; final memory images and ack timing are checked too.
module tb_top_level_instantiation;
   import hamming_pkg::*;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   logic req     = 1'b0;
   logic ack;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] exp_q [$];
   logic [7:0]  src_img [0:2*NUM_MSG-1];
   logic [10:0] msg [0:NUM_MSG-1];

   top_level_instantiation dut (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (req),
      .ack     (ack)
   );

   always #5 clock = ~clock;

   // Positional Hamming(15,11): data at non-power-of-two positions, parity bit
   // at position 2^j covers every position with bit j set; p0 covers all.
   function automatic logic [15:0] ref_code(input logic [10:0] d);
      logic [15:1] pos;
      logic [3:0]  syn;
      int          k;
      pos = '0;
      k   = 0;
      for (int q = 1; q <= 15; q++) begin
         if (q != 1 && q != 2 && q != 4 && q != 8) begin
            pos[q] = d[k];
            k++;
         end
      end
      syn = '0;
      for (int q = 1; q <= 15; q++) begin
         if (pos[q]) syn = syn ^ 4'(q);
      end
      pos[1] = syn[0];
      pos[2] = syn[1];
      pos[4] = syn[2];
      pos[8] = syn[3];
      return {pos, ^pos};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every DUT memory write must match the head of the queue.
   always @(negedge clock) begin
      logic [15:0] e;
      if (dut.w_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                     dut.w_addr, dut.w_wdata);
         end else begin
            e = exp_q.pop_front();
            check("mem_write", {16'h0, dut.w_addr, dut.w_wdata}, {16'h0, e});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic load(input int i, input logic [7:0] lo, input logic [7:0] hi);
      dut.DM.core[SRC_BASE + 2*i]     = lo;
      dut.DM.core[SRC_BASE + 2*i + 1] = hi;
      src_img[2*i]     = lo;
      src_img[2*i + 1] = hi;
      msg[i]           = {hi[2:0], lo};
   endtask

   task automatic prep_dst();
      for (int a = DST_BASE; a < DST_BASE + 2*NUM_MSG; a++) dut.DM.core[a] = 8'hAA;
      dut.DM.core[DST_BASE + 2*NUM_MSG] = 8'h5A;
   endtask

   task automatic push_expected();
      logic [15:0] c;
      for (int i = 0; i < NUM_MSG; i++) begin
         c = ref_code(msg[i]);
         exp_q.push_back({8'(DST_BASE + 2*i + 1), c[15:8]});
         exp_q.push_back({8'(DST_BASE + 2*i), c[7:0]});
      end
   endtask

   // Pulse req, then count cycles until ack; optionally re-pulse req mid-run.
   task automatic run_req(input int busy_at);
      int n;
      @(negedge clock);
      req = 1'b1;
      @(negedge clock);
      req = 1'b0;
      n = 0;
      while (ack !== 1'b1 && n < 100) begin
         req = (n == busy_at);
         @(negedge clock);
         n++;
      end
      req = 1'b0;
      check("ack_latency", n, 60);
      @(negedge clock);
      check("ack_held", {31'h0, ack}, 32'h1);
   endtask

   task automatic verify_mem();
      logic [15:0] c;
      for (int i = 0; i < NUM_MSG; i++) begin
         c = ref_code(msg[i]);
         check("code_hi", {24'h0, dut.DM.core[DST_BASE + 2*i + 1]}, {24'h0, c[15:8]});
         check("code_lo", {24'h0, dut.DM.core[DST_BASE + 2*i]}, {24'h0, c[7:0]});
      end
      for (int j = 0; j < 2*NUM_MSG; j++) begin
         check("src_kept", {24'h0, dut.DM.core[SRC_BASE + j]}, {24'h0, src_img[j]});
      end
      check("beyond_dst", {24'h0, dut.DM.core[DST_BASE + 2*NUM_MSG]}, 32'h5A);
      check("queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check("reset_ack", {31'h0, ack}, 32'h0);
      reset_n = 1'b1;
      @(negedge clock);
      check("idle_ack", {31'h0, ack}, 32'h0);

      // All-zero messages give all-zero codewords.
      for (int i = 0; i < NUM_MSG; i++) load(i, 8'h00, 8'h00);
      prep_dst();
      push_expected();
      run_req(-1);
      verify_mem();

      // Directed corner messages followed by random ones.
      load(0, 8'hFF, 8'h07);
      load(1, 8'h01, 8'h00);
      load(2, 8'h00, 8'hFC);
      for (int i = 3; i < NUM_MSG; i++)
         load(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      prep_dst();
      push_expected();
      run_req(-1);
      check("d7ff_hi", {24'h0, dut.DM.core[31]}, 32'hFF);
      check("d7ff_lo", {24'h0, dut.DM.core[30]}, 32'hFF);
      check("d001_hi", {24'h0, dut.DM.core[33]}, 32'h00);
      check("d001_lo", {24'h0, dut.DM.core[32]}, 32'h0F);
      check("d400_hi", {24'h0, dut.DM.core[35]}, 32'h81);
      check("d400_lo", {24'h0, dut.DM.core[34]}, 32'h17);
      verify_mem();

      // Abort a run with reset, then a full run with a req pulse while busy.
      for (int i = 0; i < NUM_MSG; i++)
         load(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      prep_dst();
      push_expected();
      @(negedge clock);
      req = 1'b1;
      @(negedge clock);
      req = 1'b0;
      repeat (20) @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      check("ack_in_reset", {31'h0, ack}, 32'h0);
      exp_q.delete();
      @(negedge clock);
      check("ack_in_reset2", {31'h0, ack}, 32'h0);
      reset_n = 1'b1;
      @(negedge clock);
      check("ack_after_reset", {31'h0, ack}, 32'h0);
      push_expected();
      run_req(30);
      verify_mem();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
